// File: rtl/alu_cmp_sequencer.sv
// Command-side sequencer for the ALU comparison unit.
// Optional wait watchdog compiled in with ALU_SEQ_TIMEOUT_EN.
module alu_cmp_sequencer #(
  parameter int alu_width = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [alu_width-1:0] cmd_a,
  input  logic [alu_width-1:0] cmd_b,
  input  logic [1:0]           cmd_fun,
  output logic [alu_width-1:0] alu_a,
  output logic [alu_width-1:0] alu_b,
  output logic [1:0]           alu_fun,
  output logic                 comp_enable,
  input  logic                 comp_flag,
  input  logic [alu_width-1:0] comp_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [alu_width-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_d;

  logic [alu_width-1:0] a_d, b_d, data_d;
  logic [1:0]           fun_d;
  logic                 en_d, rdy_d, vld_d, busy_d;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt, cnt_d;
  logic          err_d;
`endif

  always_comb begin
    state_d = state;
    a_d     = alu_a;
    b_d     = alu_b;
    fun_d   = alu_fun;
    data_d  = rsp_data;
    en_d    = 1'b0;
    rdy_d   = 1'b0;
    vld_d   = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    cnt_d   = cnt;
    err_d   = rsp_err;
`endif
    unique case (state)
      IDLE: begin
        rdy_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          fun_d   = cmd_fun;
          en_d    = 1'b1;
          rdy_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (comp_flag) begin
          data_d  = comp_out;
          vld_d   = 1'b1;
          state_d = RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt == LIM) begin
          data_d  = '0;
          err_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt + CW'(1);
`endif
        end
      end
      RESP: begin
        vld_d = 1'b1;
        if (rsp_ready) begin
          vld_d   = 1'b0;
          data_d  = '0;
          rdy_d   = 1'b1;
          state_d = IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_fun     <= '0;
      comp_enable <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      alu_a       <= a_d;
      alu_b       <= b_d;
      alu_fun     <= fun_d;
      comp_enable <= en_d;
      cmd_ready   <= rdy_d;
      rsp_valid   <= vld_d;
      rsp_data    <= data_d;
      busy        <= busy_d;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      rsp_err <= err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmp_sequencer.sv
// Directed bench for alu_cmp_sequencer.
// Timeout steps follow ALU_SEQ_TIMEOUT_EN.
module tb_alu_cmp_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a, cmd_b;
  logic [1:0]   cmd_fun;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_fun;
  logic         comp_enable;
  logic         comp_flag;
  logic [W-1:0] comp_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_cmp_sequencer #(.alu_width(W), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .cmd_fun(cmd_fun),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_fun(alu_fun),
    .comp_enable(comp_enable),
    .comp_flag(comp_flag),
    .comp_out(comp_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_fun   = 2'b00;
    comp_flag = 1'b0;
    comp_out  = '0;
    rsp_ready = 1'b0;

    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", comp_enable, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_fun", alu_fun, 0);
    rst = 1'b0;
    tick();

    // equal compare, immediate response
    cmd_valid = 1'b1;
    cmd_a     = 16'h1234;
    cmd_b     = 16'h1234;
    cmd_fun   = 2'b01;
    rsp_ready = 1'b1;
    chk("eq_c0_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("eq_c1_en", comp_enable, 1);
    chk("eq_c1_ready", cmd_ready, 0);
    chk("eq_c1_busy", busy, 1);
    chk("eq_c1_alu_a", alu_a, 16'h1234);
    chk("eq_c1_alu_b", alu_b, 16'h1234);
    chk("eq_c1_fun", alu_fun, 1);
    tick();
    chk("eq_c2_en", comp_enable, 0);
    chk("eq_c2_valid", rsp_valid, 0);
    comp_flag = 1'b1;
    comp_out  = 16'h0001;
    tick();
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("eq_c3_valid", rsp_valid, 1);
    chk("eq_c3_data", rsp_data, 1);
    chk("eq_c3_err", rsp_err, 0);
    chk("eq_c3_ready", cmd_ready, 0);
    tick();
    chk("eq_c4_ready", cmd_ready, 1);
    chk("eq_c4_valid", rsp_valid, 0);
    chk("eq_c4_data", rsp_data, 0);
    chk("eq_c4_busy", busy, 0);

    // stray flag in IDLE
    comp_flag = 1'b1;
    comp_out  = 16'hFFFF;
    tick();
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("idle_flag_busy", busy, 0);
    chk("idle_flag_ready", cmd_ready, 1);
    chk("idle_flag_valid", rsp_valid, 0);
    chk("idle_flag_data", rsp_data, 0);

    // back-pressure with a stray flag in RESP
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = 16'h0005;
    cmd_b     = 16'h0003;
    cmd_fun   = 2'b10;
    tick();
    cmd_valid = 1'b0;
    chk("bp_c1_fun", alu_fun, 2);
    tick();
    comp_flag = 1'b1;
    comp_out  = 16'h0001;
    tick();
    comp_flag = 1'b0;
    comp_out  = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 1);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_alu_a", alu_a, 16'h0005);
      comp_flag = (i == 2);
      comp_out  = (i == 2) ? 16'hABCD : 16'h0000;
      tick();
    end
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("bp_hold_valid", rsp_valid, 1);
    chk("bp_hold_data", rsp_data, 1);
    rsp_ready = 1'b1;
    tick();
    chk("bp_done_ready", cmd_ready, 1);
    chk("bp_done_valid", rsp_valid, 0);
    chk("bp_done_busy", busy, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // watchdog: no flag
    cmd_valid = 1'b1;
    cmd_a     = 16'h0001;
    cmd_b     = 16'h0002;
    cmd_fun   = 2'b11;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      chk("to_wait_valid", rsp_valid, 0);
      tick();
    end
    chk("to_c6_valid", rsp_valid, 1);
    chk("to_c6_err", rsp_err, 1);
    chk("to_c6_data", rsp_data, 0);
    tick();
    chk("to_done_err", rsp_err, 0);
    chk("to_done_ready", cmd_ready, 1);

    // flag in the last WAIT cycle wins
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      chk("tl_wait_valid", rsp_valid, 0);
      comp_flag = (c == 5);
      comp_out  = (c == 5) ? 16'h0001 : 16'h0000;
      tick();
    end
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("tl_c6_valid", rsp_valid, 1);
    chk("tl_c6_err", rsp_err, 0);
    chk("tl_c6_data", rsp_data, 1);
    tick();
`else
    // no watchdog: WAIT holds until the flag
    cmd_valid = 1'b1;
    cmd_a     = 16'h0001;
    cmd_b     = 16'h0002;
    cmd_fun   = 2'b11;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c < 12; c++) begin
      chk("nw_wait_valid", rsp_valid, 0);
      chk("nw_wait_busy", busy, 1);
      comp_flag = (c == 11);
      comp_out  = (c == 11) ? 16'h0001 : 16'h0000;
      tick();
    end
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("nw_valid", rsp_valid, 1);
    chk("nw_err", rsp_err, 0);
    chk("nw_data", rsp_data, 1);
    tick();
`endif
    chk("pre_rst_ready", cmd_ready, 1);

    // reset during WAIT, then a late flag
    cmd_valid = 1'b1;
    cmd_a     = 16'h0007;
    cmd_b     = 16'h0007;
    cmd_fun   = 2'b01;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mr_in_wait", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_alu_a", alu_a, 0);
    comp_flag = 1'b1;
    comp_out  = 16'h0001;
    tick();
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("mr_late_valid", rsp_valid, 0);
    chk("mr_late_busy", busy, 0);

    // lt command after reset
    cmd_valid = 1'b1;
    cmd_a     = 16'h0002;
    cmd_b     = 16'h0009;
    cmd_fun   = 2'b11;
    tick();
    cmd_valid = 1'b0;
    chk("lt_c1_en", comp_enable, 1);
    chk("lt_c1_fun", alu_fun, 3);
    chk("lt_c1_b", alu_b, 9);
    tick();
    comp_flag = 1'b1;
    comp_out  = 16'h0001;
    tick();
    comp_flag = 1'b0;
    comp_out  = '0;
    chk("lt_valid", rsp_valid, 1);
    chk("lt_data", rsp_data, 1);
    chk("lt_err", rsp_err, 0);
    tick();
    chk("lt_done_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmp_sequencer.md
# alu_cmp_sequencer

Command-side initiator for the ALU comparison unit. It accepts a comparison command (A, B, function) on a valid/ready handshake and drives the unit's operand and enable inputs. It waits for the unit's registered `comp_flag`, then returns the captured `comp_out` on a valid/ready response port. An optional watchdog ends a wait that receives no flag and returns an error response instead.

## Interface
- `alu_width`, 16, operand and result width; must match the comparison unit.
- `TIMEOUT`, 4, maximum WAIT cycles before an error response; must be ≥1; used only with `ALU_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_a` in `alu_width`: operand A.
- `cmd_b` in `alu_width`: operand B.
- `cmd_fun` in 2: comparison function (00 nop, 01 eq, 10 gt, 11 lt).
- `alu_a` out `alu_width`: operand A to the comparison unit.
- `alu_b` out `alu_width`: operand B to the comparison unit.
- `alu_fun` out 2: function to the comparison unit.
- `comp_enable` out 1: comparison unit enable, one-cycle pulse.
- `comp_flag` in 1: result-valid flag from the comparison unit.
- `comp_out` in `alu_width`: result from the comparison unit.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out `alu_width`: captured result.
- `rsp_err` out 1: response is a timeout error.
- `busy` out 1: high in every state except IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0, except `cmd_ready`, which resets to 1 because IDLE is the reset state.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch `cmd_a`, `cmd_b`, `cmd_fun` into `alu_a`, `alu_b`, `alu_fun`, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `comp_enable`=1.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - `comp_enable`=0.
  - `alu_a`, `alu_b`, `alu_fun` are held stable.
  - On `comp_flag`=1, capture `comp_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Otherwise increment the wait counter.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held.
  - On `rsp_ready`, clear `rsp_valid`, `rsp_err` and `rsp_data`, then go to IDLE.
- `cmd_ready`=0 in ISSUE, WAIT and RESP. Only one command is in flight at a time; there is no command bypass or queue.
- `comp_flag` outside WAIT is ignored and has no effect on state.
- `comp_out` is captured at full `alu_width` with no sign extension or truncation. Function 00 still issues and returns the unit's output (0).
- Reset mid-operation: the FSM returns to IDLE on the next edge, the pending command and response are discarded, and a flag arriving afterwards is ignored.

## Timing
- Cycle 0: command handshake.
- Cycle 1: ISSUE, `comp_enable`=1.
- Cycle 2: WAIT. The comparison unit's registered flag is visible here and is captured at the end of the cycle.
- Cycle 3: `rsp_valid`=1.
- Command-to-response latency is 3 cycles. With `rsp_ready` held high, `cmd_ready` returns in cycle 4, giving a 4-cycle minimum per operation.
- `rsp_ready` low stalls in RESP indefinitely with the response unchanged.
- Watchdog: with the counter at `TIMEOUT`-1 and no flag, the next edge sets `rsp_data`=0, `rsp_err`=1 and enters RESP.
- A flag in the same cycle as the counter limit wins: the response is normal, with `rsp_err`=0.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined: the wait counter and timeout exit are compiled in, and `TIMEOUT` applies.
- `ALU_SEQ_TIMEOUT_EN` undefined: no counter. WAIT exits only on `comp_flag`, and `rsp_err` is tied to 0.

## Test plan
- Reset check: `rst`=1 for 2 cycles → all outputs 0 except `cmd_ready`=1; `busy`=0.
- Equal compare with immediate response:
  - Stimulus: A=0x1234, B=0x1234, fun=01, `rsp_ready`=1; flag returned with result 1 one cycle after enable.
  - Response: `comp_enable` pulses in cycle 1 only; `rsp_valid` in cycle 3 with `rsp_data`=1, `rsp_err`=0; `cmd_ready` high in cycle 4.
- Back-pressure: A=0x0005, B=0x0003, fun=10, `rsp_ready`=0 for 5 cycles → `rsp_data`=1 held constant and `cmd_ready`=0 throughout; IDLE one cycle after `rsp_ready` rises.
- Stray flags: pulse `comp_flag` in IDLE and in RESP → no state change and no response corruption.
- Timeout (`ALU_SEQ_TIMEOUT_EN`, `TIMEOUT`=4): flag never returned → `rsp_valid` in cycle 6 with `rsp_err`=1, `rsp_data`=0. Repeat with the flag arriving in the last WAIT cycle → `rsp_err`=0.
- Reset mid-operation: assert `rst` during WAIT, then drive the flag → IDLE, no `rsp_valid`; a following lt command (A=2, B=9) returns `rsp_data`=1.
